// File: rtl/matrix_io_sequencer.sv
// Bit-serial word loader, depth_p-word buffer and timer/handshake drain sequencer.
// Optional feature macro MATRIX_IO_SEQUENCER_REPLAY_EN: drain loops until an entry bit aborts it.
module matrix_io_sequencer #(
  parameter int width_p       = 8,
  parameter int depth_p       = 4,
  parameter int hold_cycles_p = 12000000
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         bit_valid_i,
  input  logic                         bit_i,
  input  logic                         mode_i,
  input  logic                         yumi_i,
  output logic [width_p-1:0]           partial_o,
  output logic [$clog2(width_p+1)-1:0] bit_count_o,
  output logic [$clog2(depth_p+1)-1:0] count_o,
  output logic [width_p-1:0]           word_o,
  output logic                         valid_o,
  output logic                         busy_o,
  output logic                         step_o
);
  localparam int BCW = $clog2(width_p+1);
  localparam int CW  = $clog2(depth_p+1);
  localparam int PW  = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam int HW  = (hold_cycles_p > 1) ? $clog2(hold_cycles_p) : 1;

  typedef enum logic {LOAD = 1'b0, DRAIN = 1'b1} state_t;

  state_t             r_state;
  logic [width_p-1:0] r_partial;
  logic [BCW-1:0]     r_bit_count;
  logic [CW-1:0]      r_count;
  logic [PW-1:0]      r_rd_ptr;
  logic [HW-1:0]      r_hold;
  logic               r_mode;
  logic [width_p-1:0] r_buf [depth_p];

  logic               w_drain, w_retire, w_last, w_abort, w_accept, w_complete;
  logic [width_p-1:0] w_base, w_shift;
  logic [BCW-1:0]     w_base_bcnt;
  logic [CW-1:0]      w_base_count;

  assign w_drain  = (r_state == DRAIN);
  assign w_retire = w_drain & (r_mode ? yumi_i : (r_hold == HW'(hold_cycles_p-1)));
  assign w_last   = (r_rd_ptr == PW'(depth_p-1));

`ifdef MATRIX_IO_SEQUENCER_REPLAY_EN
  assign w_abort = w_drain & bit_valid_i;
`else
  assign w_abort = 1'b0;
`endif

  // An aborting bit restarts assembly from an empty word and an empty buffer.
  assign w_accept     = bit_valid_i & (~w_drain | w_abort);
  assign w_base       = w_abort ? '0 : r_partial;
  assign w_base_bcnt  = w_abort ? '0 : r_bit_count;
  assign w_base_count = w_abort ? '0 : r_count;
  assign w_shift      = (w_base << 1) | width_p'(bit_i);
  assign w_complete   = w_accept & (w_base_bcnt == BCW'(width_p-1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= LOAD;
      r_partial   <= '0;
      r_bit_count <= '0;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_hold      <= '0;
      r_mode      <= 1'b0;
    end else if (w_accept) begin
      if (w_complete) begin
        r_partial   <= '0;
        r_bit_count <= '0;
        r_count     <= w_base_count + CW'(1);
        if (w_base_count == CW'(depth_p-1)) begin
          r_state  <= DRAIN;
          r_mode   <= mode_i;
          r_rd_ptr <= '0;
          r_hold   <= '0;
        end else begin
          r_state <= LOAD;
        end
      end else begin
        r_partial   <= w_shift;
        r_bit_count <= w_base_bcnt + BCW'(1);
        r_count     <= w_base_count;
        r_state     <= LOAD;
      end
    end else if (w_drain) begin
      if (w_retire) begin
        r_hold <= '0;
        if (w_last) begin
          r_rd_ptr <= '0;
`ifndef MATRIX_IO_SEQUENCER_REPLAY_EN
          r_state  <= LOAD;
`endif
        end else begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
`ifndef MATRIX_IO_SEQUENCER_REPLAY_EN
        r_count <= r_count - CW'(1);
`endif
      end else if (!r_mode) begin
        r_hold <= r_hold + HW'(1);
      end
    end
  end

  // Storage carries no reset; contents are only observable while draining.
  always_ff @(posedge clk_i) begin
    if (w_complete) r_buf[w_base_count[PW-1:0]] <= w_shift;
  end

  assign partial_o   = r_partial;
  assign bit_count_o = r_bit_count;
  assign count_o     = r_count;
  assign valid_o     = w_drain;
  assign busy_o      = w_drain;
  assign step_o      = w_retire;
  assign word_o      = w_drain ? r_buf[r_rd_ptr] : '0;

endmodule

// File: tb/tb_matrix_io_sequencer.sv
// Table-driven directed bench for matrix_io_sequencer (width 8, depth 4, hold 4).
module tb_matrix_io_sequencer;
  localparam int W = 8;
  localparam int D = 4;
  localparam int H = 4;
`ifdef MATRIX_IO_SEQUENCER_REPLAY_EN
  localparam bit REPLAY = 1'b1;
`else
  localparam bit REPLAY = 1'b0;
`endif

  typedef struct {
    logic       bv, b, mode, yumi;
    logic [7:0] partial;
    logic [3:0] bcnt;
    logic [2:0] cnt;
    logic [7:0] word;
    logic       valid, step;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  logic clk = 1'b0, rst_n = 1'b0, bv = 1'b0, b = 1'b0, mode = 1'b0, yumi = 1'b0;
  logic [W-1:0] partial, word;
  logic [3:0]   bcnt;
  logic [2:0]   cnt;
  logic         valid, busy, step;

  matrix_io_sequencer #(.width_p(W), .depth_p(D), .hold_cycles_p(H)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .bit_valid_i(bv), .bit_i(b), .mode_i(mode),
    .yumi_i(yumi), .partial_o(partial), .bit_count_o(bcnt), .count_o(cnt),
    .word_o(word), .valid_o(valid), .busy_o(busy), .step_o(step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".partial"}, 32'(partial), 0);
    chk({nm, ".bcnt"}, 32'(bcnt), 0);
    chk({nm, ".count"}, 32'(cnt), 0);
    chk({nm, ".word"}, 32'(word), 0);
    chk({nm, ".valid"}, 32'(valid), 0);
    chk({nm, ".busy"}, 32'(busy), 0);
    chk({nm, ".step"}, 32'(step), 0);
  endtask

  task automatic add(input logic bv_, input logic b_, input logic m_, input logic y_,
                     input logic [7:0] p, input int bc, input int c,
                     input logic [7:0] w, input logic v, input logic s);
    vec_t e;
    e.bv = bv_; e.b = b_; e.mode = m_; e.yumi = y_;
    e.partial = p; e.bcnt = 4'(bc); e.cnt = 3'(c); e.word = w; e.valid = v; e.step = s;
    vq.push_back(e);
  endtask

  // Bits go in MSB first; before bit j the partial holds the top j bits.
  task automatic load_word(input logic [7:0] w, input logic m, input int c);
    for (int j = 0; j < 8; j++) add(1'b1, w[7-j], m, 1'b0, w >> (8-j), j, c, 8'h00, 1'b0, 1'b0);
  endtask

  // Timer drain; yumi held high and mode_i flipped to show both are ignored.
  task automatic drain_timer(input logic [3:0][7:0] ws, input int nw, input bit inject);
    for (int k = 0; k < nw; k++)
      for (int c = 0; c < H; c++) begin
        logic inj;
        inj = inject && k == 1 && c == 1;
        add(inj, inj, 1'b1, 1'b1, 8'h00, 0, REPLAY ? 4 : 4-k, ws[3-k], 1'b1, c == H-1);
      end
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      bv = vq[i].bv; b = vq[i].b; mode = vq[i].mode; yumi = vq[i].yumi;
      #1;
      chk($sformatf("%s.v%0d.partial", tag, i), 32'(partial), 32'(vq[i].partial));
      chk($sformatf("%s.v%0d.bcnt", tag, i), 32'(bcnt), 32'(vq[i].bcnt));
      chk($sformatf("%s.v%0d.count", tag, i), 32'(cnt), 32'(vq[i].cnt));
      chk($sformatf("%s.v%0d.word", tag, i), 32'(word), 32'(vq[i].word));
      chk($sformatf("%s.v%0d.valid", tag, i), 32'(valid), 32'(vq[i].valid));
      chk($sformatf("%s.v%0d.busy", tag, i), 32'(busy), 32'(vq[i].valid));
      chk($sformatf("%s.v%0d.step", tag, i), 32'(step), 32'(vq[i].step));
      @(posedge clk); #1;
    end
    bv = 1'b0; b = 1'b0; mode = 1'b0; yumi = 1'b0;
    vq.delete();
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0; bv = 1'b0; b = 1'b0; mode = 1'b0; yumi = 1'b0;
    #1;
    chk_zero({tag, ".rst"});
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // Phase 1: 0xA5 lands in slot 0, then a timer drain shows it first.
    do_reset("p1");
    load_word(8'hA5, 1'b0, 0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1, 8'h00, 1'b0, 1'b0);
    load_word(8'h11, 1'b0, 1);
    load_word(8'h22, 1'b0, 2);
    load_word(8'h33, 1'b0, 3);
    drain_timer({8'hA5, 8'h11, 8'h22, 8'h33}, 4, !REPLAY);
    if (REPLAY) begin
      add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 4, 8'hA5, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1, 0, 8'h00, 1'b0, 1'b0);
    end else begin
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 8'h00, 1'b0, 1'b0);
    end
    run_vecs("p1");

    // Phase 2: handshake drain, stalls then single and back-to-back yumi.
    do_reset("p2");
    load_word(8'h11, 1'b1, 0);
    load_word(8'h22, 1'b1, 1);
    load_word(8'h33, 1'b1, 2);
    load_word(8'h44, 1'b1, 3);
    for (int i = 0; i < 20; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 4, 8'h11, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 4, 8'h11, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, REPLAY ? 4 : 3, 8'h22, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, REPLAY ? 4 : 3, 8'h22, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, REPLAY ? 4 : 2, 8'h33, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, REPLAY ? 4 : 1, 8'h44, 1'b1, 1'b1);
    if (REPLAY) begin
      add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 4, 8'h11, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1, 0, 8'h00, 1'b0, 1'b0);
    end else begin
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0, 8'h00, 1'b0, 1'b0);
    end
    run_vecs("p2");

    // Phase 3: asynchronous reset while 0x33 is presented.
    do_reset("p3");
    load_word(8'h11, 1'b0, 0);
    load_word(8'h22, 1'b0, 1);
    load_word(8'h33, 1'b0, 2);
    load_word(8'h44, 1'b0, 3);
    drain_timer({8'h11, 8'h22, 8'h33, 8'h44}, 2, 1'b0);
    run_vecs("p3");
    #1;
    chk("p3.pre.word", 32'(word), 32'h33);
    chk("p3.pre.valid", 32'(valid), 1);
    chk("p3.pre.count", 32'(cnt), REPLAY ? 4 : 2);
    #1 rst_n = 1'b0;
    #1;
    chk_zero("p3.async");
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    chk_zero("p3.post");
    bv = 1'b1; b = 1'b1;
    @(posedge clk); #1 bv = 1'b0; b = 1'b0;
    #1;
    chk("p3.load.partial", 32'(partial), 1);
    chk("p3.load.bcnt", 32'(bcnt), 1);
    chk("p3.load.valid", 32'(valid), 0);
    chk("p3.load.count", 32'(cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_io_sequencer.md
# matrix_io_sequencer

Parametrised bit-serial loader, word buffer and drain sequencer for the iCEBreaker systolic-array harness. It assembles bit-serial operator entry into `width_p`-bit words and stores `depth_p` of them. When the buffer is full, it presents the words one at a time for display or for a downstream consumer, stepping either on a fixed hold timer or on a valid/yumi handshake. It sits between the button-input conditioning (synchroniser, debouncer, edge detector) and the seven-segment / systolic-array datapath.

## Interface

Parameters:
- `width_p`, 8: bits per word; ≥1.
- `depth_p`, 4: words per buffer fill; ≥1.
- `hold_cycles_p`, 12000000: clock cycles each word is presented in timer mode; ≥1.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `bit_valid_i`  in  1  one-cycle strobe: `bit_i` is a new entry bit.
- `bit_i`  in  1  entry bit value.
- `mode_i`  in  1  0 = timer drain, 1 = handshake drain; latched on LOAD→DRAIN.
- `yumi_i`  in  1  consumer accepts `word_o` (handshake mode only).
- `partial_o`  out  `width_p`  word currently being assembled.
- `bit_count_o`  out  $clog2(width_p+1)  bits in `partial_o`.
- `count_o`  out  $clog2(depth_p+1)  words stored.
- `word_o`  out  `width_p`  word currently presented.
- `valid_o`  out  1  `word_o` is valid (DRAIN state).
- `busy_o`  out  1  high in DRAIN; entry bits are not accepted.
- `step_o`  out  1  one-cycle pulse when the presented word retires.

## Operation

- FSM states: LOAD and DRAIN. Reset state is LOAD.
- LOAD, assembly:
  - On `bit_valid_i`, `partial_o <= {partial_o[width_p-2:0], bit_i}`, so the first bit entered ends up as the MSB.
  - `bit_count_o` increments with each accepted bit.
- LOAD, word completion (on the `width_p`-th bit):
  - The word `{partial_o[width_p-2:0], bit_i}` is written to buffer slot `count_o`.
  - `count_o` increments; `partial_o` and `bit_count_o` clear on the same edge.
- LOAD→DRAIN: on the edge that writes word `depth_p-1`.
  - `mode_i` is latched, the read pointer is set to 0 and the hold counter cleared.
- DRAIN, presentation: `valid_o=1`, `busy_o=1`, `word_o = buf[rd_ptr]`.
- DRAIN, retire condition:
  - Timer mode: the hold counter reaches `hold_cycles_p-1`.
  - Handshake mode: `yumi_i & valid_o`.
  - `yumi_i` is ignored in timer mode. `mode_i` changes during DRAIN have no effect.
- DRAIN, on retire:
  - `step_o` pulses, `rd_ptr` increments, the hold counter clears and `count_o` decrements.
- DRAIN→LOAD: when the word at `rd_ptr = depth_p-1` retires.
  - `count_o=0`, `valid_o=0` next cycle.
- `bit_valid_i` in DRAIN is dropped; `partial_o` and `bit_count_o` are unchanged.
- Buffer contents are not cleared on drain. `word_o` is 0 whenever `valid_o=0`.

## Timing

- Reset (asynchronous, while `reset_n_i=0`):
  - All outputs are 0, state is LOAD, pointers and counters are 0.
  - Buffer contents are undefined.
  - Reset mid-DRAIN or mid-word aborts immediately; no partial state survives.
- Bit→`partial_o` latency: 1 cycle.
- Load→present latency: `valid_o` rises the cycle after the completing `bit_valid_i`, showing word 0.
- Timer mode:
  - Each word is presented for exactly `hold_cycles_p` cycles.
  - A full drain takes `depth_p*hold_cycles_p` cycles.
- Handshake mode: `word_o` is held stable while `valid_o & ~yumi_i`. Back-to-back yumi retires one word per cycle.
- `step_o` is asserted in the same cycle as the retire condition; `word_o` changes on the following edge.
- Simultaneous events:
  - A bit arriving in the same cycle as the final retire is dropped (state is still DRAIN).
  - `depth_p=1`: LOAD→DRAIN after every word.
  - `hold_cycles_p=1`: one word per cycle.

## Configuration

- Macro: `MATRIX_IO_SEQUENCER_REPLAY_EN`.
- Without the macro, behaviour is as described above.
- With the macro defined:
  - DRAIN does not exit after word `depth_p-1`; `rd_ptr` wraps to 0 and `count_o` stays `depth_p`.
  - Presentation repeats indefinitely.
  - A `bit_valid_i` in DRAIN aborts replay: the next state is LOAD with `count_o=0`, and that bit is accepted as the first bit (`partial_o={..0,bit_i}`, `bit_count_o=1`).
  - `step_o` still pulses on each retire.

## Test plan

Bench parameters: `width_p=8`, `depth_p=4`, `hold_cycles_p=4`.

- Enter bits 1,0,1,0,0,1,0,1 → after the 8th bit: `count_o=1`, `partial_o=0`, `bit_count_o=0`; buffer slot 0 holds 0xA5.
- Load 0x11, 0x22, 0x33, 0x44 with `mode_i=0` → `valid_o` rises 1 cycle after the last bit.
  - `word_o` shows 0x11, 0x22, 0x33, 0x44, each for exactly 4 cycles; `step_o` pulses 4 times.
  - Then `valid_o=0`, `busy_o=0`, `count_o=0`.
- Same load with `mode_i=1` and `yumi_i=0` for 20 cycles → `word_o` is held at 0xA5's successor 0x11 with no step.
  - Then a yumi pulse advances to 0x22.
  - Then 3 consecutive yumi cycles finish the drain.
- During DRAIN, pulse `bit_valid_i` with `bit_i=1` → `partial_o` and `bit_count_o` stay 0; the drain sequence is unaffected.
- Assert `reset_n_i=0` asynchronously mid-DRAIN while showing 0x33 → all outputs are 0 before the next clock edge; after release, state is LOAD with `count_o=0`.
- With `MATRIX_IO_SEQUENCER_REPLAY_EN` defined:
  - After 0x44, `word_o` returns to 0x11 and `count_o` stays 4.
  - A `bit_valid_i` with `bit_i=1` gives, next cycle: `valid_o=0`, `count_o=0`, `partial_o=0x01`, `bit_count_o=1`.
